// File: rtl/axi4_stream_pkt_gen_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi4_stream_if : AXI4-Stream bundle with master/slave modports    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1
);
    logic                      tvalid;
    logic                      tready;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tkeep;
    logic [DATA_WIDTH/8-1:0]   tstrb;
    logic                      tlast;
    logic [USER_WIDTH-1:0]     tuser;
    logic [ID_WIDTH-1:0]       tid;
    logic [DEST_WIDTH-1:0]     tdest;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_stream_pkt_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi4_stream_pkt_gen : AXI4-Stream packet source with (p+b) byte   |
// | pattern, inter-packet gap and optional LFSR throttle             |
// | (macro AXI4_STREAM_PKT_GEN_THROTTLE_EN).  Rev 1.0                |
// +------------------------------------------------------------------+
module axi4_stream_pkt_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 1,
    parameter int ID_WIDTH   = 1,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [LEN_WIDTH-1:0]  pkt_len_i,
    input  logic [LEN_WIDTH-1:0]  pkt_cnt_i,
    input  logic [LEN_WIDTH-1:0]  gap_i,
    input  logic [DEST_WIDTH-1:0] dest_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_WIDTH-1:0]  pkt_sent_o,
    axi4_stream_if.master         pkt_o
);
    localparam int DATA_WIDTH_B = DATA_WIDTH / 8;
    localparam int CW           = LEN_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [LEN_WIDTH-1:0]    len_q, cnt_q, gap_q, gap_cnt_q, off_q, pkt_q;
    logic                    stop_q, busy_q, done_q;
    logic                    tvalid_q, tlast_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic [DATA_WIDTH_B-1:0] tkeep_q;
    logic [USER_WIDTH-1:0]   tuser_q;
    logic [ID_WIDTH-1:0]     tid_q;
    logic [DEST_WIDTH-1:0]   tdest_q;

    logic                    allow;
    logic                    start_ok, handshake, hs_last, stop_pend, run_end;
    logic                    load_en, drop_en;
    logic [LEN_WIDTH-1:0]    pkt_inc;
    logic [LEN_WIDTH-1:0]    len_sel, pkt_sel, off_sel;
    logic [CW-1:0]           byte_idx;
    logic [DATA_WIDTH-1:0]   tdata_d;
    logic [DATA_WIDTH_B-1:0] tkeep_d;
    logic                    tlast_d;
    logic [USER_WIDTH-1:0]   tuser_d;
    logic [ID_WIDTH-1:0]     tid_d;

`ifdef AXI4_STREAM_PKT_GEN_THROTTLE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign allow = ~lfsr_q[0];
`else
    assign allow = 1'b1;
`endif

    assign start_ok  = start_i && (pkt_len_i != '0);
    assign handshake = tvalid_q & pkt_o.tready;
    assign hs_last   = handshake & tlast_q;
    assign stop_pend = stop_q | stop_i;
    assign pkt_inc   = pkt_q + LEN_WIDTH'(1);
    assign run_end   = hs_last & (stop_pend | ((cnt_q != '0) && (pkt_inc == cnt_q)));

    // Select which (packet, byte offset) the next presented word belongs to.
    always_comb begin
        len_sel = len_q;
        pkt_sel = pkt_q;
        off_sel = off_q;
        load_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                len_sel = pkt_len_i;
                pkt_sel = '0;
                off_sel = '0;
                load_en = start_ok & allow;
            end
            S_SEND: begin
                if (hs_last) begin
                    pkt_sel = pkt_inc;
                    off_sel = '0;
                end else if (handshake) begin
                    off_sel = off_q + LEN_WIDTH'(DATA_WIDTH_B);
                end
                load_en = allow & (~tvalid_q | (handshake & ~(hs_last & (run_end | (gap_q != '0)))));
            end
            S_GAP: begin
                off_sel = '0;
                load_en = allow & ~stop_pend & (gap_cnt_q == LEN_WIDTH'(1));
            end
            default: load_en = 1'b0;
        endcase
        drop_en = handshake & ~load_en;
    end

    always_comb begin
        tdata_d  = '0;
        tkeep_d  = '0;
        byte_idx = '0;
        for (int i = 0; i < DATA_WIDTH_B; i++) begin
            byte_idx = {1'b0, off_sel} + CW'(i);
            if (byte_idx < {1'b0, len_sel}) begin
                tdata_d[8*i +: 8] = pkt_sel[7:0] + byte_idx[7:0];
                tkeep_d[i]        = 1'b1;
            end
        end
        tlast_d    = ({1'b0, off_sel} + CW'(DATA_WIDTH_B)) >= {1'b0, len_sel};
        tuser_d    = '0;
        tuser_d[0] = (off_sel == '0);
        tid_d      = ID_WIDTH'(pkt_sel);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            off_q     <= '0;
            pkt_q     <= '0;
            stop_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tlast_q   <= 1'b0;
            tuser_q   <= '0;
            tid_q     <= '0;
            tdest_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        len_q   <= pkt_len_i;
                        cnt_q   <= pkt_cnt_i;
                        gap_q   <= gap_i;
                        tdest_q <= dest_i;
                        pkt_q   <= '0;
                        off_q   <= '0;
                        stop_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (stop_i) begin
                        stop_q <= 1'b1;
                    end
                    if (handshake) begin
                        off_q <= off_sel;
                    end
                    if (hs_last) begin
                        pkt_q <= pkt_inc;
                        if (run_end) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (gap_q != '0) begin
                            gap_cnt_q <= gap_q;
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (stop_pend) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (gap_cnt_q == LEN_WIDTH'(1)) begin
                        state_q <= S_SEND;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - LEN_WIDTH'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Payload is cleared whenever tvalid drops so idle beats carry zeros.
            if (load_en) begin
                tvalid_q <= 1'b1;
                tdata_q  <= tdata_d;
                tkeep_q  <= tkeep_d;
                tlast_q  <= tlast_d;
                tuser_q  <= tuser_d;
                tid_q    <= tid_d;
            end else if (drop_en) begin
                tvalid_q <= 1'b0;
                tdata_q  <= '0;
                tkeep_q  <= '0;
                tlast_q  <= 1'b0;
                tuser_q  <= '0;
                tid_q    <= '0;
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pkt_sent_o   = pkt_q;
    assign pkt_o.tvalid = tvalid_q;
    assign pkt_o.tdata  = tdata_q;
    assign pkt_o.tkeep  = tkeep_q;
    assign pkt_o.tstrb  = tkeep_q;
    assign pkt_o.tlast  = tlast_q;
    assign pkt_o.tuser  = tuser_q;
    assign pkt_o.tid    = tid_q;
    assign pkt_o.tdest  = tdest_q;
endmodule
`default_nettype wire

// File: tb/tb_axi4_stream_pkt_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi4_stream_pkt_gen : directed bench for axi4_stream_pkt_gen   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_axi4_stream_pkt_gen;
    logic        clk = 1'b0;
    logic        rst, start, stop, dest;
    logic [15:0] len, cnt, gap;
    logic        busy, done;
    logic [15:0] sent;

    always #5 clk = ~clk;

    axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) s_if ();

    axi4_stream_pkt_gen #(
        .DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1), .LEN_WIDTH(16)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .stop_i    (stop),
        .pkt_len_i (len),
        .pkt_cnt_i (cnt),
        .gap_i     (gap),
        .dest_i    (dest),
        .busy_o    (busy),
        .done_o    (done),
        .pkt_sent_o(sent),
        .pkt_o     (s_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_done = 0;
    int n_viol = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    logic        q_last[$];
    logic        q_user[$];
    logic        q_tid[$];
    int          q_cyc[$];

    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change just after posedge, so negedge sees the values the next edge will use.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) n_done++;
            if (prev_valid && !prev_hs && (!s_if.tvalid || s_if.tdata != prev_data)) n_viol++;
            if (s_if.tvalid && s_if.tready) begin
                q_data.push_back(s_if.tdata);
                q_keep.push_back(s_if.tkeep);
                q_last.push_back(s_if.tlast);
                q_user.push_back(s_if.tuser[0]);
                q_tid.push_back(s_if.tid);
                q_cyc.push_back(cyc);
            end
        end
        prev_valid = s_if.tvalid && !rst;
        prev_hs    = s_if.tvalid && s_if.tready;
        prev_data  = s_if.tdata;
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete(); q_keep.delete(); q_last.delete();
        q_user.delete(); q_tid.delete(); q_cyc.delete();
    endtask

    // Packed compare: {data, keep, last, user, tid}.
    task automatic check_word(input string tag, input int i, input logic [31:0] d,
                              input logic [3:0] k, input logic l, input logic u, input logic t);
        if (i >= q_data.size()) begin
            check_value({tag, "_present"}, 64'(q_data.size()), 64'(i + 1));
        end else begin
            check_value(tag, {25'd0, q_data[i], q_keep[i], q_last[i], q_user[i], q_tid[i]},
                             {25'd0, d, k, l, u, t});
        end
    endtask

    task automatic wait_done(input int max_cyc, output int dcyc);
        for (int k = 0; k < max_cyc && !done; k++) tick();
        check_value("done_seen", 64'(done), 64'd1);
        check_value("busy_at_done", 64'(busy), 64'd0);
        dcyc = cyc;
    endtask

    task automatic start_run(input logic [15:0] l, input logic [15:0] c, input logic [15:0] g);
        len = l; cnt = c; gap = g; start = 1'b1;
        clear_q();
        tick();
        start = 1'b0;
    endtask

    initial begin
        int dcyc;
        int nd;
        rst = 1'b1; start = 1'b0; stop = 1'b0; dest = 1'b0;
        len = '0; cnt = '0; gap = '0;
        s_if.tready = 1'b1;
        repeat (3) tick();
        check_value("rst_outputs", {s_if.tvalid, s_if.tdata, s_if.tkeep, s_if.tstrb, s_if.tlast,
                                    s_if.tuser, s_if.tid, s_if.tdest, busy, done, sent}, 64'd0);
        rst = 1'b0;
        tick();

`ifndef AXI4_STREAM_PKT_GEN_THROTTLE_EN
        // len=10, cnt=2, gap=3
        dest = 1'b1;
        nd = n_done;
        start_run(16'd10, 16'd2, 16'd3);
        check_value("t1_first_valid", {s_if.tvalid, busy, s_if.tdest}, 3'b111);
        check_value("t1_first_data", 64'(s_if.tdata), 64'h03020100);
        wait_done(60, dcyc);
        tick(); tick();
        check_word("t1_p0w0", 0, 32'h03020100, 4'hF, 1'b0, 1'b1, 1'b0);
        check_word("t1_p0w1", 1, 32'h07060504, 4'hF, 1'b0, 1'b0, 1'b0);
        check_word("t1_p0w2", 2, 32'h00000908, 4'h3, 1'b1, 1'b0, 1'b0);
        check_word("t1_p1w0", 3, 32'h04030201, 4'hF, 1'b0, 1'b1, 1'b1);
        check_word("t1_p1w1", 4, 32'h08070605, 4'hF, 1'b0, 1'b0, 1'b1);
        check_word("t1_p1w2", 5, 32'h00000A09, 4'h3, 1'b1, 1'b0, 1'b1);
        if (q_cyc.size() == 6) begin
            check_value("t1_pkt0_span", 64'(q_cyc[2] - q_cyc[0]), 64'd2);
            check_value("t1_gap", 64'(q_cyc[3] - q_cyc[2]), 64'd4);
            check_value("t1_done_timing", 64'(dcyc), 64'(q_cyc[5] + 1));
        end else begin
            check_value("t1_word_count", 64'(q_cyc.size()), 64'd6);
        end
        check_value("t1_done_pulses", 64'(n_done - nd), 64'd1);
        check_value("t1_pkt_sent", 64'(sent), 64'd2);

        // len=8, cnt=1
        dest = 1'b0;
        start_run(16'd8, 16'd1, 16'd0);
        wait_done(20, dcyc);
        check_value("t2_count", 64'(q_data.size()), 64'd2);
        check_word("t2_w0", 0, 32'h03020100, 4'hF, 1'b0, 1'b1, 1'b0);
        check_word("t2_w1", 1, 32'h07060504, 4'hF, 1'b1, 1'b0, 1'b0);
        check_value("t2_pkt_sent", 64'(sent), 64'd1);

        // tready stall of 5 cycles on word 1
        start_run(16'd16, 16'd1, 16'd0);
        tick();
        s_if.tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_value("t3_stall_hold", {31'd0, s_if.tvalid, s_if.tdata}, {31'd1, 32'h07060504});
        end
        s_if.tready = 1'b1;
        wait_done(20, dcyc);
        check_value("t3_count", 64'(q_data.size()), 64'd4);
        check_word("t3_w0", 0, 32'h03020100, 4'hF, 1'b0, 1'b1, 1'b0);
        check_word("t3_w1", 1, 32'h07060504, 4'hF, 1'b0, 1'b0, 1'b0);
        check_word("t3_w2", 2, 32'h0B0A0908, 4'hF, 1'b0, 1'b0, 1'b0);
        check_word("t3_w3", 3, 32'h0F0E0D0C, 4'hF, 1'b1, 1'b0, 1'b0);
        check_value("t3_no_drop", 64'(n_viol), 64'd0);

        // endless run stopped during packet 3
        start_run(16'd8, 16'd0, 16'd0);
        repeat (6) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(20, dcyc);
        check_value("t4_count", 64'(q_data.size()), 64'd8);
        check_word("t4_p3w0", 6, 32'h06050403, 4'hF, 1'b0, 1'b1, 1'b1);
        check_word("t4_p3w1", 7, 32'h0A090807, 4'hF, 1'b1, 1'b0, 1'b1);
        if (q_cyc.size() == 8) begin
            check_value("t4_back_to_back", 64'(q_cyc[7] - q_cyc[0]), 64'd7);
            check_value("t4_done_timing", 64'(dcyc), 64'(q_cyc[7] + 1));
        end
        check_value("t4_pkt_sent", 64'(sent), 64'd4);

        // reset during word 1 of a 4-word packet, then len=0 start
        start_run(16'd16, 16'd1, 16'd0);
        tick();
        rst = 1'b1;
        tick();
        check_value("t5_rst_outputs", {s_if.tvalid, s_if.tdata, s_if.tkeep, s_if.tlast,
                                       s_if.tuser, s_if.tid, busy, done, sent}, 64'd0);
        rst = 1'b0;
        start_run(16'd0, 16'd1, 16'd0);
        check_value("t5_len0_ignored", {62'd0, busy, s_if.tvalid}, 64'd0);
        tick();
        check_value("t5_len0_idle", {62'd0, busy, s_if.tvalid}, 64'd0);
        check_value("t5_words_before_rst", 64'(q_data.size()), 64'd0);
`else
        // throttled run, len=64, tready toggling
        start_run(16'd64, 16'd1, 16'd0);
        for (int k = 0; k < 2000 && !done; k++) begin
            s_if.tready = 1'($urandom_range(0, 1));
            tick();
        end
        s_if.tready = 1'b1;
        check_value("thr_done_seen", 64'(done), 64'd1);
        check_value("thr_count", 64'(q_data.size()), 64'd16);
        for (int w = 0; w < 16; w++) begin
            logic [7:0] b0;
            b0 = 8'(4 * w);
            check_word($sformatf("thr_w%0d", w), w, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0},
                       4'hF, (w == 15), (w == 0), 1'b0);
        end
        check_value("thr_no_drop", 64'(n_viol), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
